// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: sequences data-cache read/write handshakes,
// stalls the pipeline until each access completes, and implements LL/SC with snoop invalidation.
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              memcuDRE,
  input  logic              memcuDWE,
  input  logic              memdatomic,
  input  logic [ADDR_W-1:0] memaddr,
  input  logic [WORD_W-1:0] memstore,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              ccinv,
  input  logic [ADDR_W-1:0] ccsnoopaddr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              memStall,
  output logic [WORD_W-1:0] memrdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_linkvalid;
  logic [ADDR_W-1:0] r_linkaddr;
  logic              r_atomic;

  logic w_req;
  logic w_is_sc;
  logic w_snoop_hit;
  logic w_sc_addr_match;
  logic w_sc_fail;
  logic w_store_link_match;
  logic w_unused;

  assign w_req   = memcuDRE | memcuDWE;
  // Both enables set means a read, so an SC needs DWE alone.
  assign w_is_sc = memcuDWE & ~memcuDRE & memdatomic;

  assign w_snoop_hit        = ccinv & (ccsnoopaddr[ADDR_W-1:2] == r_linkaddr[ADDR_W-1:2]);
  assign w_sc_addr_match    = (memaddr[ADDR_W-1:2] == r_linkaddr[ADDR_W-1:2]);
  assign w_sc_fail          = w_is_sc & (~r_linkvalid | ~w_sc_addr_match | w_snoop_hit);
  assign w_store_link_match = (dmemaddr[ADDR_W-1:2] == r_linkaddr[ADDR_W-1:2]);

  assign w_unused = ^{ccsnoopaddr[1:0], memaddr[1:0], r_linkaddr[1:0]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    memStall = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          memStall = 1'b1;
          w_next   = w_sc_fail ? DONE : REQ;
        end
      end
      REQ: begin
        memStall = 1'b1;
        if (dhit) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dmemREN     <= 1'b0;
      dmemWEN     <= 1'b0;
      dmemaddr    <= '0;
      dmemstore   <= '0;
      memrdata    <= '0;
      r_linkvalid <= 1'b0;
      r_linkaddr  <= '0;
      r_atomic    <= 1'b0;
    end else begin
      if (w_snoop_hit) begin
        r_linkvalid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if (w_sc_fail) begin
              memrdata    <= '0;
              r_linkvalid <= 1'b0;
            end else begin
              dmemREN   <= memcuDRE;
              dmemWEN   <= memcuDWE & ~memcuDRE;
              dmemaddr  <= memaddr;
              dmemstore <= memstore;
              r_atomic  <= memdatomic;
            end
          end
        end
        REQ: begin
          if (dhit) begin
            dmemREN <= 1'b0;
            dmemWEN <= 1'b0;
            if (dmemREN) begin
              memrdata <= dmemload;
              // A completing LL overrides a same-cycle snoop clear.
              if (r_atomic) begin
                r_linkvalid <= 1'b1;
                r_linkaddr  <= dmemaddr;
              end
            end else if (r_atomic) begin
              memrdata    <= WORD_W'(1);
              r_linkvalid <= 1'b0;
            end else if (w_store_link_match) begin
              r_linkvalid <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
